// File: rtl/idma_mchan_job_arbiter.sv
// Multi-channel iDMA job front-end: per-channel job FIFOs, round-robin issue
// to one backend, and in-order completion tracking to per-channel busy/IRQ.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   job_i, job_valid_i      per-channel job push (chan c at [c*JobWidth +: JobWidth])
//   job_ready_o             per-channel FIFO not full
//   stream_id_i             static per-channel IOMMU stream ID
//   be_job_o, be_chan_o,    registered backend job with channel tag and stream ID
//   be_stream_id_o
//   be_valid_o, be_ready_i  backend job handshake
//   be_done_i               in-order completion pulse for the oldest issued job
//   chan_busy_o             channel has queued/issued/uncompleted jobs
//   irq_o, irq_clear_i      sticky per-channel completion interrupt and clear
//   err_o                   sticky: completion seen with nothing outstanding
//
// Build option: define IDMA_MCHAN_PRIO_EN to make channel 0 strict
// high-priority; the remaining channels then round-robin among themselves.

module idma_mchan_job_arbiter #(
    parameter int NumChan        = 4,
    parameter int JobFifoDepth   = 4,
    parameter int JobWidth       = 128,
    parameter int StreamIdWidth  = 4,
    parameter int MaxOutstanding = 8,
    localparam int ChanW         = $clog2(NumChan)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumChan*JobWidth-1:0]      job_i,
    input  logic [NumChan-1:0]               job_valid_i,
    output logic [NumChan-1:0]               job_ready_o,
    input  logic [NumChan*StreamIdWidth-1:0] stream_id_i,
    output logic [JobWidth-1:0]              be_job_o,
    output logic [ChanW-1:0]                 be_chan_o,
    output logic [StreamIdWidth-1:0]         be_stream_id_o,
    output logic                             be_valid_o,
    input  logic                             be_ready_i,
    input  logic                             be_done_i,
    output logic [NumChan-1:0]               chan_busy_o,
    output logic [NumChan-1:0]               irq_o,
    input  logic [NumChan-1:0]               irq_clear_i,
    output logic                             err_o
);

    localparam int FPW = $clog2(JobFifoDepth);
    localparam int TPW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int TCW = $clog2(MaxOutstanding + 1);
    localparam int PW  = $clog2(JobFifoDepth + MaxOutstanding + 2);

    // Channel FIFOs. vptr trails wptr by one cycle so a freshly written
    // entry only becomes eligible for arbitration on the following cycle.
    logic [JobWidth-1:0] fifo_mem [NumChan][JobFifoDepth];
    logic [FPW:0]        wptr     [NumChan];
    logic [FPW:0]        vptr     [NumChan];
    logic [FPW:0]        rptr     [NumChan];
    logic [NumChan-1:0]  fifo_full;
    logic [NumChan-1:0]  fifo_avail;
    logic [NumChan-1:0]  push;
    logic [NumChan-1:0]  pop;
    logic [NumChan-1:0]  dec;

    logic [ChanW-1:0]    rr_ptr;
    logic [ChanW-1:0]    grant;
    logic                grant_vld;
    logic [ChanW-1:0]    idx;

    logic [ChanW-1:0]    trk_mem [MaxOutstanding];
    logic [TPW-1:0]      trk_wptr;
    logic [TPW-1:0]      trk_rptr;
    logic [TCW-1:0]      trk_cnt;
    logic [ChanW-1:0]    trk_head;
    logic [TCW:0]        occ;

    logic [PW-1:0]       pending [NumChan];

    logic                be_hs;
    logic                done_eff;
    logic                issue_ok;
    logic                load;

    function automatic logic [TPW-1:0] trk_inc(input logic [TPW-1:0] p);
        return (p == TPW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            fifo_full[c]   = (wptr[c] ^ rptr[c]) == {1'b1, {FPW{1'b0}}};
            fifo_avail[c]  = vptr[c] != rptr[c];
            push[c]        = job_valid_i[c] & ~fifo_full[c];
            job_ready_o[c] = ~fifo_full[c];
            chan_busy_o[c] = pending[c] != '0;
        end
    end

    // First available channel at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
`ifdef IDMA_MCHAN_PRIO_EN
        if (fifo_avail[0]) begin
            grant_vld = 1'b1;
        end
`endif
        for (int i = 0; i < NumChan; i++) begin
            idx = ChanW'((int'(rr_ptr) + i) % NumChan);
`ifdef IDMA_MCHAN_PRIO_EN
            if (!grant_vld && idx != '0 && fifo_avail[idx]) begin
`else
            if (!grant_vld && fifo_avail[idx]) begin
`endif
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign trk_head = trk_mem[trk_rptr];
    assign be_hs    = be_valid_o & be_ready_i;
    assign done_eff = be_done_i & (trk_cnt != '0);

    // Jobs in the tracker plus the one in the output register never
    // exceed MaxOutstanding.
    assign occ = {1'b0, trk_cnt} + (TCW+1)'(be_valid_o)
               - (TCW+1)'(done_eff);
    assign issue_ok = occ < (TCW+1)'(MaxOutstanding);
    assign load = (~be_valid_o | be_ready_i) & issue_ok & grant_vld;

    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            pop[c] = load & (grant == ChanW'(c));
            dec[c] = done_eff & (trk_head == ChanW'(c));
        end
    end

    // Storage arrays carry no reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            if (push[c]) begin
                fifo_mem[c][wptr[c][FPW-1:0]] <= job_i[c*JobWidth +: JobWidth];
            end
        end
        if (be_hs) begin
            trk_mem[trk_wptr] <= be_chan_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChan; c++) begin
                wptr[c]    <= '0;
                vptr[c]    <= '0;
                rptr[c]    <= '0;
                pending[c] <= '0;
            end
            rr_ptr         <= '0;
            be_job_o       <= '0;
            be_chan_o      <= '0;
            be_stream_id_o <= '0;
            be_valid_o     <= 1'b0;
            trk_wptr       <= '0;
            trk_rptr       <= '0;
            trk_cnt        <= '0;
            irq_o          <= '0;
            err_o          <= 1'b0;
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                vptr[c] <= wptr[c];
                if (push[c]) wptr[c] <= wptr[c] + 1'b1;
                if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
                case ({push[c], dec[c]})
                    2'b10:   pending[c] <= pending[c] + 1'b1;
                    2'b01:   pending[c] <= pending[c] - 1'b1;
                    default: ;
                endcase
                irq_o[c] <= dec[c] | (irq_o[c] & ~irq_clear_i[c]);
            end

            if (load) begin
                be_valid_o     <= 1'b1;
                be_job_o       <= fifo_mem[grant][rptr[grant][FPW-1:0]];
                be_chan_o      <= grant;
                be_stream_id_o <= stream_id_i[grant*StreamIdWidth +: StreamIdWidth];
`ifdef IDMA_MCHAN_PRIO_EN
                if (grant != '0) begin
                    rr_ptr <= (grant == ChanW'(NumChan-1)) ? '0 : grant + 1'b1;
                end
`else
                rr_ptr <= (grant == ChanW'(NumChan-1)) ? '0 : grant + 1'b1;
`endif
            end else if (be_hs) begin
                be_valid_o <= 1'b0;
            end

            if (be_hs)    trk_wptr <= trk_inc(trk_wptr);
            if (done_eff) trk_rptr <= trk_inc(trk_rptr);
            case ({be_hs, done_eff})
                2'b10:   trk_cnt <= trk_cnt + 1'b1;
                2'b01:   trk_cnt <= trk_cnt - 1'b1;
                default: ;
            endcase

            if (be_done_i && trk_cnt == '0) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_idma_mchan_job_arbiter.sv
// Self-checking bench for idma_mchan_job_arbiter: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_idma_mchan_job_arbiter;

    localparam int NC   = 4;
    localparam int D    = 4;
    localparam int JW   = 128;
    localparam int SW   = 4;
    localparam int MAXO = 8;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic [NC*JW-1:0] job_i = '0;
    logic [NC-1:0]    job_valid_i = '0;
    logic [NC-1:0]    job_ready_o;
    logic [NC*SW-1:0] stream_id_i = 16'hFB73;
    logic [JW-1:0]    be_job_o;
    logic [1:0]       be_chan_o;
    logic [SW-1:0]    be_stream_id_o;
    logic             be_valid_o;
    logic             be_ready_i = 1'b0;
    logic             be_done_i = 1'b0;
    logic [NC-1:0]    chan_busy_o;
    logic [NC-1:0]    irq_o;
    logic [NC-1:0]    irq_clear_i = '0;
    logic             err_o;

    idma_mchan_job_arbiter #(
        .NumChan(NC), .JobFifoDepth(D), .JobWidth(JW),
        .StreamIdWidth(SW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .job_i(job_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .stream_id_i(stream_id_i), .be_job_o(be_job_o),
        .be_chan_o(be_chan_o), .be_stream_id_o(be_stream_id_o),
        .be_valid_o(be_valid_o), .be_ready_i(be_ready_i),
        .be_done_i(be_done_i), .chan_busy_o(chan_busy_o),
        .irq_o(irq_o), .irq_clear_i(irq_clear_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sid(input int c);
        return 4'(4 * c + 3);
    endfunction

    // ---------------- reference model ----------------
    logic [127:0] cq_job   [NC][$];
    int           cq_stamp [NC][$];
    int           trk[$];
    int           pend [NC];
    int           m_pushed [NC];
    logic [NC-1:0] m_irq = '0;
    logic         m_err = 1'b0;
    logic         m_valid = 1'b0;
    logic [127:0] m_job = '0;
    int           m_chan = 0;
    int           rr = 0;
    int           edge_k = 0;

    initial begin
        for (int c = 0; c < NC; c++) begin
            pend[c] = 0;
            m_pushed[c] = 0;
        end
    end

    // A job pushed at edge k may be issued at edge k+2 at the earliest.
    function automatic bit elig(input int c);
        return cq_job[c].size() > 0 && cq_stamp[c][0] + 2 <= edge_k;
    endfunction

    always @(posedge clk) begin : mdl
        logic [NC-1:0] rdy;
        logic [NC-1:0] setm;
        logic hs, de, ld;
        int g, idx, cc;
        edge_k++;
        if (rst_i) begin
            for (int c = 0; c < NC; c++) begin
                cq_job[c].delete();
                cq_stamp[c].delete();
                pend[c] = 0;
            end
            trk.delete();
            m_irq = '0; m_err = 1'b0; m_valid = 1'b0;
            m_job = '0; m_chan = 0; rr = 0;
        end else begin
            for (int c = 0; c < NC; c++) rdy[c] = cq_job[c].size() < D;
            hs = m_valid && be_ready_i;
            de = be_done_i && trk.size() > 0;
            if (be_done_i && !de) m_err = 1'b1;
            g = -1;
`ifdef IDMA_MCHAN_PRIO_EN
            if (elig(0)) g = 0;
`endif
            for (int i = 0; i < NC; i++) begin
                idx = (rr + i) % NC;
`ifdef IDMA_MCHAN_PRIO_EN
                if (g < 0 && idx != 0 && elig(idx)) g = idx;
`else
                if (g < 0 && elig(idx)) g = idx;
`endif
            end
            ld = (!m_valid || be_ready_i)
               && (trk.size() + int'(m_valid) - int'(de) < MAXO) && g >= 0;
            setm = '0;
            if (de) begin
                cc = trk.pop_front();
                pend[cc]--;
                setm[cc] = 1'b1;
            end
            m_irq = (m_irq & ~irq_clear_i) | setm;
            if (hs) trk.push_back(m_chan);
            if (ld) begin
                m_job = cq_job[g].pop_front();
                void'(cq_stamp[g].pop_front());
                m_chan = g;
                m_valid = 1'b1;
`ifdef IDMA_MCHAN_PRIO_EN
                if (g != 0) rr = (g + 1) % NC;
`else
                rr = (g + 1) % NC;
`endif
            end else if (hs) begin
                m_valid = 1'b0;
            end
            for (int c = 0; c < NC; c++) begin
                if (job_valid_i[c] && rdy[c]) begin
                    cq_job[c].push_back(job_i[c*JW +: JW]);
                    cq_stamp[c].push_back(edge_k);
                    pend[c]++;
                    m_pushed[c]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    int obs[$];
    int acc [NC];

    always @(negedge clk) begin : cmp
        logic [NC-1:0] er, eb;
        for (int c = 0; c < NC; c++) begin
            er[c] = cq_job[c].size() < D;
            eb[c] = pend[c] != 0;
        end
        check("be_valid", be_valid_o, m_valid);
        if (m_valid) begin
            check("be_job", be_job_o, m_job);
            check("be_chan", be_chan_o, m_chan);
            check("be_stream_id", be_stream_id_o, sid(m_chan));
        end
        check("job_ready", job_ready_o, er);
        check("chan_busy", chan_busy_o, eb);
        check("irq", irq_o, m_irq);
        check("err", err_o, m_err);
        if (be_valid_o && be_ready_i) obs.push_back(int'(be_chan_o));
        for (int c = 0; c < NC; c++)
            if (job_valid_i[c] && job_ready_o[c]) acc[c]++;
    end

    // ---------------- stimulus ----------------
    logic auto_done = 1'b0;

    task automatic drive_jobs();
        for (int c = 0; c < NC; c++)
            job_i[c*JW +: JW] = {8'(c), 56'h0, 64'(m_pushed[c])};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_done) be_done_i = trk.size() != 0;
        drive_jobs();
    endtask

    int exp_order [16];
    logic [127:0] bp_job;
    logic [NC-1:0] irq_save;

    initial begin
`ifdef IDMA_MCHAN_PRIO_EN
        exp_order = '{0,0,0,0,1,2,3,1,2,3,1,2,3,1,2,3};
`else
        for (int i = 0; i < 16; i++) exp_order[i] = i % 4;
`endif
        for (int c = 0; c < NC; c++) acc[c] = 0;
        drive_jobs();

        // reset state
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_be_valid", be_valid_o, 1'b0);
        check("rst_job_ready", job_ready_o, 4'hF);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", chan_busy_o, 4'h0);

        // fairness
        be_ready_i = 1'b1;
        auto_done = 1'b1;
        obs.delete();
        job_valid_i = 4'hF;
        repeat (4) tick();
        job_valid_i = '0;
        repeat (20) tick();
        check("fair_count", obs.size(), 16);
        for (int i = 0; i < 16; i++)
            check("fair_order", (i < obs.size()) ? obs[i] : 99, exp_order[i]);
        irq_clear_i = 4'hF;
        tick();
        irq_clear_i = '0;

        // backpressure
        auto_done = 1'b0;
        be_done_i = 1'b0;
        be_ready_i = 1'b0;
        for (int c = 0; c < NC; c++) acc[c] = 0;
        bp_job = {8'd1, 56'h0, 64'(m_pushed[1])};
        job_valid_i = 4'b1010;
        repeat (10) tick();
        job_valid_i = '0;
        check("bp_job_held", be_job_o, bp_job);
        check("bp_chan", be_chan_o, 2'd1);
        check("bp_acc_ch1", acc[1], 5);
        check("bp_acc_ch3", acc[3], 4);
        check("bp_ready", job_ready_o & 4'b1010, 4'b0000);
        be_ready_i = 1'b1;
        auto_done = 1'b1;
        repeat (30) tick();
        auto_done = 1'b0;
        be_done_i = 1'b0;
        tick();
        check("drained_busy", chan_busy_o, 4'h0);

        // outstanding cap
        obs.delete();
        job_valid_i = 4'b0001;
        repeat (20) tick();
        job_valid_i = '0;
        check("cap_hs", obs.size(), MAXO);
        check("cap_valid", be_valid_o, 1'b0);
        be_done_i = 1'b1;
        tick();
        be_done_i = 1'b0;
        repeat (5) tick();
        check("cap_one_more", obs.size(), MAXO + 1);
        auto_done = 1'b1;
        repeat (30) tick();
        auto_done = 1'b0;
        be_done_i = 1'b0;
        irq_clear_i = 4'hF;
        tick();
        irq_clear_i = '0;

        // completion
        job_valid_i = 4'b0100;
        repeat (3) tick();
        job_valid_i = '0;
        repeat (8) tick();
        check("cmp_busy0", chan_busy_o[2], 1'b1);
        check("cmp_irq0", irq_o[2], 1'b0);
        be_done_i = 1'b1;
        tick();
        be_done_i = 1'b0;
        check("cmp_irq1", irq_o[2], 1'b1);
        check("cmp_busy1", chan_busy_o[2], 1'b1);
        be_done_i = 1'b1;
        tick();
        be_done_i = 1'b0;
        tick();
        be_done_i = 1'b1;
        irq_clear_i = 4'b0100;
        tick();
        be_done_i = 1'b0;
        irq_clear_i = '0;
        check("cmp_irq_set_wins", irq_o[2], 1'b1);
        check("cmp_busy3", chan_busy_o[2], 1'b0);

        // spurious done
        irq_save = irq_o;
        check("spur_err_pre", err_o, 1'b0);
        be_done_i = 1'b1;
        tick();
        be_done_i = 1'b0;
        tick();
        check("spur_err", err_o, 1'b1);
        check("spur_irq", irq_o, irq_save);
        check("spur_busy", chan_busy_o, 4'h0);
        tick();
        check("spur_sticky", err_o, 1'b1);

        // reset mid-traffic, then late completion
        job_valid_i = 4'hF;
        be_ready_i = 1'b1;
        repeat (6) tick();
        rst_i = 1'b1;
        job_valid_i = '0;
        tick(); tick();
        check("mrst_valid", be_valid_o, 1'b0);
        check("mrst_ready", job_ready_o, 4'hF);
        check("mrst_err", err_o, 1'b0);
        check("mrst_irq", irq_o, 4'h0);
        check("mrst_busy", chan_busy_o, 4'h0);
        rst_i = 1'b0;
        tick();
        be_done_i = 1'b1;
        tick();
        be_done_i = 1'b0;
        tick();
        check("late_done_err", err_o, 1'b1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
